if_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end. Successor to the single-register PC/IF stage.
- Keeps a fetch PC and issues pipelined requests to the instruction SRAM. The SRAM uses a req/gnt handshake with in-order responses of variable latency.
- Buffers returned instructions with their PCs in a FIFO of depth FIFO_DEPTH. Delivers them to ID over a valid/ready handshake.
- On a branch redirect it flushes the queue and discards in-flight responses.

---
 rtl/if_fetch_queue_if.sv | 44 ++++
 rtl/if_fetch_queue.sv | 116 +++++++++++
 tb/tb_if_fetch_queue.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: branch redirect input, instruction-SRAM request/response
// port and the valid/ready delivery port towards ID.
//
// Handshake rules, shared by both channels that use them:
//   - isram_req/isram_gnt: a request moves only when req && gnt in the same
//     cycle. While req is high without gnt, isram_addr is held stable.
//     Responses (isram_rvalid/isram_rdata) come back in request order and
//     are never back-pressured.
//   - id_valid/id_ready: the head entry moves only when valid && ready in
//     the same cycle. While valid is high without ready, id_pc/id_inst hold.
interface if_fetch_queue_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              br_e;
    logic [ADDR_W-1:0] br_addr;
    logic              isram_req;
    logic [ADDR_W-1:0] isram_addr;
    logic              isram_gnt;
    logic              isram_rvalid;
    logic [INST_W-1:0] isram_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    // Fetch queue side
    modport master (
        input  br_e, br_addr,
        input  isram_gnt, isram_rvalid, isram_rdata,
        input  id_ready,
        output isram_req, isram_addr,
        output id_valid, id_pc, id_inst
    );

    // Environment side: branch unit, instruction SRAM and ID stage
    modport slave (
        output br_e, br_addr,
        output isram_gnt, isram_rvalid, isram_rdata,
        output id_ready,
        input  isram_req, isram_addr,
        input  id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: keeps a fetch PC, issues credit-limited
// pipelined requests to the instruction SRAM, queues the in-order responses
// together with their PCs and hands them to ID. A redirect flushes the queue
// and arranges for every response still in flight to be thrown away.
module if_fetch_queue #(
    parameter int                ADDR_W     = 64,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(64'h8000_0000),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Architectural state
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [INST_W-1:0] r_mem_inst [FIFO_DEPTH];

    logic [CNT_W:0]    w_committed;
    logic              w_credit_ok;
    logic              w_req;
    logic              w_grant;
    logic              w_resp;
    logic              w_drop;
    logic              w_push;
    logic              w_valid;
    logic              w_pop;
    logic [ADDR_W-1:0] w_target;
    logic              w_unused;

    // Queue slots already claimed: buffered entries plus requests in flight.
    // Keeping this below the depth guarantees every response finds a slot.
    assign w_committed = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit_ok = w_committed < (CNT_W+1)'(FIFO_DEPTH);

    assign w_req   = !rst && !bus.br_e && w_credit_ok;
    assign w_grant = w_req && bus.isram_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp  = bus.isram_rvalid && (r_outstanding != '0);
    assign w_drop  = w_resp && (bus.br_e || (r_drop_cnt != '0));
    assign w_push  = !rst && w_resp && !w_drop;

    assign w_valid = !rst && (r_count != '0);
    assign w_pop   = w_valid && bus.id_ready && !bus.br_e;

    // Redirect targets are forced to word alignment.
    assign w_target = {bus.br_addr[ADDR_W-1:2], 2'b00};
    assign w_unused = ^bus.br_addr[1:0];

    assign bus.isram_req  = w_req;
    assign bus.isram_addr = r_fetch_pc;
    assign bus.id_valid   = w_valid;
    assign bus.id_pc      = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign bus.id_inst    = w_valid ? r_mem_inst[r_rd_ptr] : '0;

    // PCs, credit/drop counters and queue pointers; reset, then redirect,
    // then normal request/response/delivery bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= PC_RESET;
            r_resp_pc     <= PC_RESET;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (bus.br_e) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= r_outstanding - CNT_W'(w_resp);
            // Every request still in flight after this cycle is stale. Any
            // earlier pending drops are already part of r_outstanding, so
            // the new drop count is simply what remains outstanding; this
            // keeps back-to-back redirects from over-counting.
            r_drop_cnt    <= r_outstanding - CNT_W'(w_resp);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + ADDR_W'(4);
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Queue storage: write the returning instruction with its PC at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
            r_mem_inst[r_wr_ptr] <= bus.isram_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue. The bench plays the instruction SRAM
// and the ID stage, and keeps a queue-level reference model of the fetch
// front end that is compared against the DUT every cycle.
module tb_if_fetch_queue;
    localparam int          ADDR_W     = 64;
    localparam int          INST_W     = 32;
    localparam int          DEPTH      = 4;
    localparam logic [63:0] PC_RST     = 64'h8000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    if_fetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W),
        .PC_RESET(PC_RST), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic        doomed;
    } flight_t;

    flight_t           inflight_q[$];  // requests granted, not yet answered
    logic [63:0]       exp_pc_q[$];    // queued PCs, head first
    logic [INST_W-1:0] exp_q[$];       // queued instructions, head first
    logic [63:0]       m_pc;           // next address to request
    int                sram_pend;      // responses the SRAM still owes

    int n_total = 0;
    int n_bad   = 0;

    // stimulus knobs (percentages)
    int          p_gnt = 100, p_rv = 100, p_rdy = 100, p_br = 0, p_spur = 0;
    bit          force_br = 0;
    bit          fixed_br = 0;
    logic [63:0] fixed_target = 64'h0;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit do_rst);
        logic        e_req, e_valid;
        logic [63:0] e_pc;
        logic [63:0] e_inst;
        flight_t     f;

        @(negedge clk);
        rst              = do_rst;
        bus.br_e         = !do_rst && (force_br || ($urandom_range(99) < p_br));
        bus.br_addr      = fixed_br ? fixed_target : {$urandom, $urandom};
        bus.isram_gnt    = ($urandom_range(99) < p_gnt);
        if (do_rst)
            bus.isram_rvalid = 1'b0;
        else if (sram_pend > 0)
            bus.isram_rvalid = ($urandom_range(99) < p_rv);
        else
            bus.isram_rvalid = ($urandom_range(99) < p_spur);
        bus.isram_rdata  = $urandom;
        bus.id_ready     = ($urandom_range(99) < p_rdy);
        #1;

        // expectations from the model
        e_req   = !do_rst && !bus.br_e && ((exp_q.size() + inflight_q.size()) < DEPTH);
        e_valid = !do_rst && (exp_q.size() > 0);
        e_pc    = e_valid ? exp_pc_q[0] : 64'h0;
        e_inst  = e_valid ? 64'(exp_q[0]) : 64'h0;

        chk("isram_req", 64'(bus.isram_req), 64'(e_req));
        if (!do_rst) chk("isram_addr", bus.isram_addr, m_pc);
        chk("id_valid", 64'(bus.id_valid), 64'(e_valid));
        chk("id_pc", bus.id_pc, e_pc);
        chk("id_inst", 64'(bus.id_inst), e_inst);

        // model update for this clock edge
        if (do_rst) begin
            inflight_q.delete();
            exp_pc_q.delete();
            exp_q.delete();
            m_pc = PC_RST;
        end else begin
            if (!bus.br_e && e_valid && bus.id_ready) begin
                void'(exp_pc_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (bus.isram_rvalid && inflight_q.size() > 0) begin
                f = inflight_q.pop_front();
                if (!bus.br_e && !f.doomed) begin
                    exp_pc_q.push_back(f.pc);
                    exp_q.push_back(bus.isram_rdata);
                end
            end
            if (bus.br_e) begin
                foreach (inflight_q[i]) inflight_q[i].doomed = 1'b1;
                exp_pc_q.delete();
                exp_q.delete();
                m_pc = {bus.br_addr[63:2], 2'b00};
            end else if (e_req && bus.isram_gnt) begin
                f.pc = m_pc;
                f.doomed = 1'b0;
                inflight_q.push_back(f);
                m_pc = m_pc + 64'd4;
            end
        end

        // SRAM side: track what the DUT actually requested
        if (do_rst) begin
            sram_pend = 0;
        end else begin
            if (bus.isram_rvalid && sram_pend > 0) sram_pend--;
            if (bus.isram_req && bus.isram_gnt) sram_pend++;
        end

        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic knobs(input int g, input int rv, input int rdy, input int br, input int sp);
        p_gnt = g; p_rv = rv; p_rdy = rdy; p_br = br; p_spur = sp;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.br_e = 0; bus.br_addr = '0; bus.isram_gnt = 0;
        bus.isram_rvalid = 0; bus.isram_rdata = '0; bus.id_ready = 0;
        m_pc = PC_RST;
        sram_pend = 0;

        // reset, then straight-line streaming
        for (int i = 0; i < 3; i++) step(1'b1);
        knobs(100, 100, 100, 0, 0);
        run(20);

        // backpressure from a fresh start: queue fills, requests stop
        step(1'b1);
        knobs(100, 100, 0, 0, 0);
        run(12);
        #1;
        chk("bp_req_stopped", 64'(bus.isram_req), 64'h0);
        chk("bp_head_valid", 64'(bus.id_valid), 64'h1);
        chk("bp_head_pc", bus.id_pc, PC_RST);
        p_rdy = 100;
        run(10);

        // grant stall: address held, then advances
        step(1'b1);
        knobs(0, 100, 100, 0, 0);
        run(3);
        p_gnt = 100;
        run(6);

        // redirect with three requests in flight, unaligned target
        step(1'b1);
        knobs(100, 0, 100, 0, 0);
        run(3);
        fixed_br = 1; fixed_target = 64'h8000_1003;
        force_br = 1; step(1'b0); force_br = 0;
        #1;
        chk("redir_addr", bus.isram_addr, 64'h8000_1000);
        p_rv = 100;
        run(12);

        // redirect on a response-and-pop cycle, second one two cycles later
        knobs(100, 100, 100, 0, 0);
        run(5);
        fixed_target = 64'h0000_4006;
        force_br = 1; step(1'b0); force_br = 0;
        run(1);
        fixed_target = 64'h0000_9001;
        force_br = 1; step(1'b0); force_br = 0;
        run(12);

        // address wrap at the top of the space
        fixed_target = 64'hFFFF_FFFF_FFFF_FFF7;
        force_br = 1; step(1'b0); force_br = 0;
        run(12);
        fixed_br = 0;

        // random mix including redirects and stray responses
        knobs(70, 50, 60, 4, 5);
        run(3000);

        // reset mid-stream with a full queue
        knobs(100, 100, 0, 0, 0);
        run(10);
        step(1'b1);
        #1;
        chk("rst_req_low", 64'(bus.isram_req), 64'h0);
        chk("rst_valid_low", 64'(bus.id_valid), 64'h0);
        knobs(100, 100, 100, 0, 0);
        run(10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
